// File: rtl/sme_and_sched.sv
// Shares one masked DOM-AND gadget between two requesters with round-robin arbitration,
// buffering fresh PRNG words so each gadget operation gets a full set of unused randomness.
module sme_and_sched #(
  parameter int D          = 3,
  parameter int XLEN       = 32,
  parameter int GADGET_LAT = 1,
  parameter int RNG_WORDS  = D*(D-1)/2
) (
  input  logic                      g_clk,
  input  logic                      g_reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [D*XLEN-1:0]         req0_rs1,
  input  logic [D*XLEN-1:0]         req0_rs2,
  input  logic [D*XLEN-1:0]         req1_rs1,
  input  logic [D*XLEN-1:0]         req1_rs2,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [D*XLEN-1:0]         rsp_rd,
  input  logic                      rng_valid,
  output logic                      rng_ready,
  input  logic [XLEN-1:0]           rng_data,
  output logic [D*XLEN-1:0]         gad_rs1,
  output logic [D*XLEN-1:0]         gad_rs2,
  output logic [RNG_WORDS*XLEN-1:0] gad_rng,
  input  logic [D*XLEN-1:0]         gad_rd
);

  localparam int CW  = $clog2(RNG_WORDS + 1);
  localparam int WCW = $clog2(GADGET_LAT + 2) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     rng_count;
  logic [XLEN-1:0]   rng_buf [RNG_WORDS];
  logic              last_grant;
  logic              owner;
  logic [WCW-1:0]    wait_cnt;
  logic [D*XLEN-1:0] op_rs1;
  logic [D*XLEN-1:0] op_rs2;
  logic [D*XLEN-1:0] rd_q;
  logic [1:0]        grant_vec;
  logic              rng_full;

  assign rng_full = (rng_count == CW'(RNG_WORDS));

  // Arbitration and next-state; a grant needs a full randomness buffer
  always_comb begin
    state_nxt = state;
    grant_vec = 2'b00;
    if (state == IDLE && rng_full) begin
      if (req_valid == 2'b11) grant_vec = last_grant ? 2'b01 : 2'b10;
      else                    grant_vec = req_valid;
    end
    case (state)
      IDLE:    if (grant_vec != 2'b00) state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = grant_vec;
  assign rng_ready = !g_reset && (state != WAIT) && !rng_full;
  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rd    = rd_q;
  assign gad_rs1   = op_rs1;
  assign gad_rs2   = op_rs2;

  for (genvar k = 0; k < RNG_WORDS; k++) begin : g_rng
    assign gad_rng[k*XLEN +: XLEN] = rng_buf[k];
  end

  // The wait counter runs down to zero so the response appears GADGET_LAT+2 edges after the grant
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state      <= IDLE;
      rng_count  <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      op_rs1     <= '0;
      op_rs2     <= '0;
      rd_q       <= '0;
      for (int k = 0; k < RNG_WORDS; k++) rng_buf[k] <= '0;
    end else begin
      state <= state_nxt;
      if (rng_valid && rng_ready) begin
        for (int k = 0; k < RNG_WORDS; k++)
          if (CW'(k) == rng_count) rng_buf[k] <= rng_data;
        rng_count <= rng_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_vec != 2'b00) begin
            op_rs1     <= grant_vec[1] ? req1_rs1 : req0_rs1;
            op_rs2     <= grant_vec[1] ? req1_rs2 : req0_rs2;
            owner      <= grant_vec[1];
            last_grant <= grant_vec[1];
            wait_cnt   <= WCW'(GADGET_LAT + 1);
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rd_q      <= gad_rd;
            rng_count <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_and_sched.sv
// Self-checking bench for sme_and_sched: queue-based randomness model, round-robin
// expectation and a behavioural DOM-AND gadget that re-masks its result with the supplied words.
module tb_sme_and_sched;

  localparam int D = 3;
  localparam int XLEN = 32;
  localparam int W = D*XLEN;

  logic          g_clk = 1'b0;
  logic          g_reset;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]  req0_rs1, req0_rs2, req1_rs1, req1_rs2, rsp_rd;
  logic          rng_valid, rng_ready;
  logic [31:0]   rng_data;
  logic [W-1:0]  gad_rs1, gad_rs2, gad_rng;
  logic [W-1:0]  gad_rd = '0;

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   rngQ[$];
  int            lastGrant;
  logic          rngOn;

  sme_and_sched dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_data(rng_data),
    .gad_rs1(gad_rs1), .gad_rs2(gad_rs2), .gad_rng(gad_rng), .gad_rd(gad_rd)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] unmask(input logic [W-1:0] s);
    return s[31:0] ^ s[63:32] ^ s[95:64];
  endfunction

  function automatic logic [W-1:0] mask(input logic [31:0] v);
    logic [31:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    return {v ^ r0 ^ r1, r1, r0};
  endfunction

  // Gadget result shares: the AND re-masked pairwise by the three randomness words
  function automatic logic [W-1:0] gadgetOut(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] r);
    return {(unmask(a) & unmask(b)) ^ r[31:0] ^ r[63:32], r[63:32] ^ r[95:64], r[31:0] ^ r[95:64]};
  endfunction

  always @(posedge g_clk) gad_rd <= gadgetOut(gad_rs1, gad_rs2, gad_rng);

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Record any PRNG handshake of this cycle, advance one edge, present new PRNG data
  task automatic tick();
    #1;
    if (rng_valid && rng_ready) rngQ.push_back(rng_data);
    @(posedge g_clk);
    #1;
    rng_valid = rngOn;
    rng_data  = $urandom;
  endtask

  // One full operation: wait for the modelled grant, follow it through WAIT and RESP
  task automatic applyStimulus(input string tag, input int hold, input bit abortMid);
    logic [1:0]   exp;
    logic [1:0]   ownVec;
    int           owner;
    int           n;
    logic [W-1:0] e1, e2, er, ed;
    n = 0;
    forever begin
      settle();
      exp = 2'b00;
      if (rngQ.size() == 3) begin
        if (req_valid == 2'b11) exp = (lastGrant == 0) ? 2'b10 : 2'b01;
        else                    exp = req_valid;
      end
      checkOutput({tag, " req_ready"}, req_ready, exp);
      checkOutput({tag, " rng_ready_idle"}, rng_ready, rngQ.size() < 3);
      checkOutput({tag, " rsp_valid_idle"}, rsp_valid, 2'b00);
      if (exp != 2'b00 || n == 40) break;
      tick();
      n++;
    end
    checkOutput({tag, " grant_seen"}, req_ready != 2'b00, 1'b1);
    if (exp == 2'b00) return;
    owner     = exp[1] ? 1 : 0;
    ownVec    = exp;
    lastGrant = owner;
    e1 = owner ? req1_rs1 : req0_rs1;
    e2 = owner ? req1_rs2 : req0_rs2;
    er = {rngQ[2], rngQ[1], rngQ[0]};
    repeat (3) void'(rngQ.pop_front());
    ed = gadgetOut(e1, e2, er);
    tick();
    if (owner == 1) begin req1_rs1 = mask($urandom); req1_rs2 = mask($urandom); end
    else            begin req0_rs1 = mask($urandom); req0_rs2 = mask($urandom); end
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput({tag, " gad_rs1"}, gad_rs1, e1);
      checkOutput({tag, " gad_rs2"}, gad_rs2, e2);
      checkOutput({tag, " gad_rng"}, gad_rng, er);
      checkOutput({tag, " rsp_valid_wait"}, rsp_valid, 2'b00);
      checkOutput({tag, " rng_ready_wait"}, rng_ready, 1'b0);
      if (abortMid && i == 1) begin
        g_reset = 1'b1;
        settle();
        checkOutput({tag, " rst_gad_rs1"}, gad_rs1, '0);
        checkOutput({tag, " rst_gad_rng"}, gad_rng, '0);
        checkOutput({tag, " rst_rsp_rd"}, rsp_rd, '0);
        checkOutput({tag, " rst_rsp_valid"}, rsp_valid, 2'b00);
        checkOutput({tag, " rst_req_ready"}, req_ready, 2'b00);
        checkOutput({tag, " rst_rng_ready"}, rng_ready, 1'b0);
        rngQ.delete();
        lastGrant = 1;
        tick();
        tick();
        g_reset = 1'b0;
        return;
      end
      tick();
    end
    rsp_ready = ~ownVec;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) rsp_ready = ownVec;
      settle();
      checkOutput({tag, " rsp_valid"}, rsp_valid, ownVec);
      checkOutput({tag, " rsp_rd"}, rsp_rd, ed);
      checkOutput({tag, " rsp_unmasked"}, unmask(rsp_rd), unmask(e1) & unmask(e2));
      checkOutput({tag, " req_ready_resp"}, req_ready, 2'b00);
      checkOutput({tag, " rng_ready_resp"}, rng_ready, rngQ.size() < 3);
      tick();
    end
    rsp_ready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] words [3];
    g_reset   = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rng_valid = 1'b0;
    rng_data  = '0;
    req0_rs1  = '0; req0_rs2 = '0; req1_rs1 = '0; req1_rs2 = '0;
    rngOn     = 1'b0;
    lastGrant = 1;
    #3;
    checkOutput("reset req_ready", req_ready, 2'b00);
    checkOutput("reset rsp_valid", rsp_valid, 2'b00);
    checkOutput("reset rng_ready", rng_ready, 1'b0);
    checkOutput("reset gad_rs1", gad_rs1, '0);
    checkOutput("reset gad_rng", gad_rng, '0);
    checkOutput("reset rsp_rd", rsp_rd, '0);
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    settle();
    checkOutput("release rng_ready", rng_ready, 1'b1);

    // Single op with fixed words, preceded by a starved PRNG
    req0_rs1  = mask(32'hF0F0F0F0);
    req0_rs2  = mask(32'hFF00FF00);
    req_valid = 2'b01;
    repeat (4) begin
      settle();
      checkOutput("starve req_ready", req_ready, 2'b00);
      tick();
    end
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      rng_valid = 1'b1;
      rng_data  = words[i];
      settle();
      checkOutput("partial req_ready", req_ready, 2'b00);
      tick();
    end
    applyStimulus("single", 0, 1'b0);
    req_valid = 2'b00;
    settle();
    checkOutput("single and", unmask(rsp_rd), 32'hF000F000);

    // Both ports contending, PRNG always valid, one long backpressure on port 1
    rngOn     = 1'b1;
    rng_valid = 1'b1;
    rng_data  = $urandom;
    req0_rs1 = mask($urandom); req0_rs2 = mask($urandom);
    req1_rs1 = mask($urandom); req1_rs2 = mask($urandom);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("alt%0d", i), (i == 2) ? 10 : $urandom_range(0, 2), 1'b0);

    applyStimulus("abort", 0, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("post%0d", i), $urandom_range(0, 3), 1'b0);

    req_valid = 2'b10;
    for (int i = 0; i < 2; i++)
      applyStimulus($sformatf("solo%0d", i), $urandom_range(0, 3), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
